// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator drain path.
//   - Default geometry of the output matrix and systolic array, with the
//     derived tile counts, accumulator row count and address width.
//   - Drain sequencer state encoding.
//   - accum_addr(): maps (tile row, row within tile, tile col) to a table row.
package accum_pkg;

  localparam int MAX_OUT_ROWS_DEF = 128;
  localparam int MAX_OUT_COLS_DEF = 128;
  localparam int SYS_ARR_ROWS_DEF = 16;
  localparam int SYS_ARR_COLS_DEF = 16;

  localparam int NUM_SUBMATS_M  = MAX_OUT_ROWS_DEF / SYS_ARR_ROWS_DEF;
  localparam int NUM_SUBMATS_N  = MAX_OUT_COLS_DEF / SYS_ARR_COLS_DEF;
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS_DEF * NUM_SUBMATS_N;
  localparam int AW             = $clog2(NUM_ACCUM_ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  // Tile columns are stacked as contiguous blocks of out_rows table rows.
  function automatic int unsigned accum_addr(
    input int unsigned m,
    input int unsigned row,
    input int unsigned n,
    input int unsigned tile_rows = SYS_ARR_ROWS_DEF,
    input int unsigned out_rows  = MAX_OUT_ROWS_DEF
  );
    return n * out_rows + m * tile_rows + row;
  endfunction

endpackage

// File: rtl/accum_out_fifo.sv
// Small synchronous FIFO buffering table read data ahead of the output stream.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (clears pointers/count only)
//   push         write push_data (dropped if full without a simultaneous pop)
//   push_data    WIDTH-bit entry
//   pop          remove head entry (ignored when empty)
//   pop_data     head entry, valid whenever empty is low
//   count        number of stored entries
//   empty, full  occupancy flags
module accum_out_fifo #(
  parameter  int WIDTH = 513,
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/accum_drain_sequencer.sv
// Drains a finished output matrix from the accumulator table to a
// valid/ready writeback stream.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start          begin a drain (only honoured in IDLE)
//   cfg_m, cfg_n   tile rows / tile cols to drain, latched on start
//   rd_en          table read strobe
//   rd_addr_out    read address replicated on every lane (0 when rd_en is low)
//   rd_data        table data, valid RD_LATENCY cycles after rd_en
//   out_valid      output beat valid
//   out_ready      downstream accepts beat
//   out_data       one tile row, SYS_ARR_COLS lanes
//   out_last       final beat of the drain
//   busy           sequencer not in IDLE
//   done           one-cycle pulse at drain completion
module accum_drain_sequencer
  import accum_pkg::*;
#(
  parameter  int MAX_OUT_ROWS = 128,
  parameter  int MAX_OUT_COLS = 128,
  parameter  int SYS_ARR_ROWS = 16,
  parameter  int SYS_ARR_COLS = 16,
  parameter  int ACC_W        = 32,
  parameter  int RD_LATENCY   = 1,
  localparam int M_TILES      = MAX_OUT_ROWS / SYS_ARR_ROWS,
  localparam int N_TILES      = MAX_OUT_COLS / SYS_ARR_COLS,
  localparam int ACC_ROWS     = MAX_OUT_ROWS * N_TILES,
  localparam int ADDR_W       = $clog2(ACC_ROWS),
  localparam int CFG_M_W      = $clog2(M_TILES) + 1,
  localparam int CFG_N_W      = $clog2(N_TILES) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [CFG_M_W-1:0]             cfg_m,
  input  logic [CFG_N_W-1:0]             cfg_n,
  output logic                           rd_en,
  output logic [ADDR_W*SYS_ARR_COLS-1:0] rd_addr_out,
  input  logic [ACC_W*SYS_ARR_COLS-1:0]  rd_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_W*SYS_ARR_COLS-1:0]  out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int ROW_W      = (SYS_ARR_ROWS > 1) ? $clog2(SYS_ARR_ROWS) : 1;
  localparam int DW         = ACC_W * SYS_ARR_COLS;

  drain_state_t        state;
  drain_state_t        state_nxt;

  logic [CFG_M_W-1:0]  cfg_m_q;
  logic [CFG_N_W-1:0]  cfg_n_q;
  logic [CFG_M_W-1:0]  sub_m;
  logic [CFG_N_W-1:0]  sub_n;
  logic [ROW_W-1:0]    sub_row;
  logic [CFG_M_W-1:0]  lim_m;
  logic [CFG_N_W-1:0]  lim_n;
  logic                last_read;

  logic [CNT_W-1:0]    inflight;
  logic [CNT_W:0]      outstanding;
  logic                credit_ok;

  logic [RD_LATENCY-1:0] vld_p;
  logic [RD_LATENCY-1:0] last_p;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CNT_W-1:0]    fifo_count;
  logic [DW:0]         fifo_head;
  logic [ADDR_W-1:0]   addr_word;

  assign lim_m     = cfg_m_q - CFG_M_W'(1);
  assign lim_n     = cfg_n_q - CFG_N_W'(1);
  assign last_read = (sub_m == lim_m) && (sub_row == ROW_W'(SYS_ARR_ROWS - 1)) && (sub_n == lim_n);

  // Credits cover both buffered beats and reads still in the table pipeline,
  // so every issued read is guaranteed a FIFO slot when its data returns.
  assign outstanding = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok   = !fifo_full && (outstanding < (CNT_W + 1)'(FIFO_DEPTH));

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ((cfg_m != '0) && (cfg_n != '0)) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        rd_en = credit_ok;
        if (credit_ok && last_read) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Finish as the final beat is accepted so done follows it directly.
        if ((inflight == '0) &&
            ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && out_ready))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_word   = ADDR_W'(accum_addr(32'(sub_m), 32'(sub_row), 32'(sub_n),
                                     SYS_ARR_ROWS, MAX_OUT_ROWS));
    rd_addr_out = rd_en ? {SYS_ARR_COLS{addr_word}} : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cfg_m_q <= '0;
      cfg_n_q <= '0;
      sub_m   <= '0;
      sub_n   <= '0;
      sub_row <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        cfg_m_q <= cfg_m;
        cfg_n_q <= cfg_n;
      end
      // Walk order: tile col innermost, then row within tile, then tile row.
      if (rd_en) begin
        if (sub_n == lim_n) begin
          sub_n <= '0;
          if (sub_row == ROW_W'(SYS_ARR_ROWS - 1)) begin
            sub_row <= '0;
            sub_m   <= (sub_m == lim_m) ? '0 : sub_m + CFG_M_W'(1);
          end else begin
            sub_row <= sub_row + ROW_W'(1);
          end
        end else begin
          sub_n <= sub_n + CFG_N_W'(1);
        end
      end
    end
  end

  // Read tag pipeline: tag reaches vld_p[RD_LATENCY-1] with its table data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p    <= '0;
      last_p   <= '0;
      inflight <= '0;
    end else begin
      vld_p[0]  <= rd_en;
      last_p[0] <= rd_en && last_read;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        last_p[i] <= last_p[i-1];
      end
      case ({rd_en, fifo_push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign fifo_push = vld_p[RD_LATENCY-1];
  assign fifo_pop  = out_valid && out_ready;

  accum_out_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({last_p[RD_LATENCY-1], rd_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[DW-1:0];
  assign out_last  = out_valid && fifo_head[DW];

endmodule

// File: tb/tb_accum_drain_sequencer.sv
// Directed bench for accum_drain_sequencer: one instance with RD_LATENCY=1 and
// one with RD_LATENCY=3, each fed by a table model whose row contents are a
// fixed function of the address.
module tb_accum_drain_sequencer;

  localparam int LANES = 16;
  localparam int ACC_W = 32;
  localparam int AW    = 10;
  localparam int DW    = LANES * ACC_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start1, start3;
  logic             out_ready;
  logic [3:0]       cfg_m, cfg_n;

  logic             rd_en1, rd_en3;
  logic [AW*LANES-1:0] rd_addr1, rd_addr3;
  logic [DW-1:0]    rd_data1, rd_data3;
  logic             out_valid1, out_valid3;
  logic [DW-1:0]    out_data1, out_data3;
  logic             out_last1, out_last3;
  logic             busy1, busy3;
  logic             done1, done3;

  accum_drain_sequencer #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cfg_m(cfg_m), .cfg_n(cfg_n),
    .rd_en(rd_en1), .rd_addr_out(rd_addr1), .rd_data(rd_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1), .done(done1)
  );

  accum_drain_sequencer #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cfg_m(cfg_m), .cfg_n(cfg_n),
    .rd_en(rd_en3), .rd_addr_out(rd_addr3), .rd_data(rd_data3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_last(out_last3), .busy(busy3), .done(done3)
  );

  function automatic logic [DW-1:0] table_row(input logic [AW-1:0] addr);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*ACC_W +: ACC_W] = {8'(l), 8'hA5, 6'b0, addr};
    return r;
  endfunction

  // Table model: data follows the address by exactly the configured latency.
  logic [AW-1:0] a1_p1, a3_p1, a3_p2, a3_p3;
  always @(posedge clk) begin
    a1_p1 <= rd_addr1[AW-1:0];
    a3_p1 <= rd_addr3[AW-1:0];
    a3_p2 <= a3_p1;
    a3_p3 <= a3_p2;
  end
  assign rd_data1 = table_row(a1_p1);
  assign rd_data3 = table_row(a3_p3);

  bit              sel;
  logic            o_rd_en, o_valid, o_last, o_busy, o_done;
  logic [AW*LANES-1:0] o_rd_addr;
  logic [DW-1:0]   o_data;
  always_comb begin
    o_rd_en   = sel ? rd_en3     : rd_en1;
    o_rd_addr = sel ? rd_addr3   : rd_addr1;
    o_valid   = sel ? out_valid3 : out_valid1;
    o_data    = sel ? out_data3  : out_data1;
    o_last    = sel ? out_last3  : out_last1;
    o_busy    = sel ? busy3      : busy1;
    o_done    = sel ? done3      : done1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // A push into a full FIFO without a simultaneous pop would lose data.
  always @(negedge clk) begin
    #2;
    if (rst_n && dut1.fifo_push)
      chk_i("fifo1_overflow", int'(dut1.fifo_full && !dut1.fifo_pop), 0);
    if (rst_n && dut3.fifo_push)
      chk_i("fifo3_overflow", int'(dut3.fifo_full && !dut3.fifo_pop), 0);
  end

  // mode: 0 ready high, 1 ready low for 20 cycles from beat 30, 2 random ready.
  // abort_at >= 0 pulls reset once that many beats are accepted.
  // poke re-asserts start with cfg_m=1 at beat 100.
  task automatic run_drain(input int m, input int n, input int mode,
                           input int abort_at, input bit poke);
    int exp_q[$];
    int total, reads, beats, done_cnt, last_cyc, stall_cnt, depth, budget;
    bit hold, poked;
    logic [DW-1:0] hold_data;
    logic hold_last;
    logic [AW-1:0] ea;
    for (int mm = 0; mm < m; mm++)
      for (int rr = 0; rr < 16; rr++)
        for (int nn = 0; nn < n; nn++)
          exp_q.push_back(nn * 128 + mm * 16 + rr);
    total = exp_q.size();
    depth = sel ? 5 : 3;
    budget = total * 6 + 50;
    reads = 0; beats = 0; done_cnt = 0; last_cyc = -1; stall_cnt = 0;
    hold = 0; poked = 0; hold_data = '0; hold_last = 0;

    @(negedge clk);
    cfg_m = 4'(m); cfg_n = 4'(n); out_ready = 1'b1;
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    cfg_m = 4'd1; cfg_n = 4'd1;

    for (int cyc = 0; cyc < budget; cyc++) begin
      if (mode == 1)      out_ready = !(beats >= 30 && stall_cnt < 20);
      else if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      else                out_ready = 1'b1;
      start1 = 1'b0;
      if (poke && !poked && beats == 100) begin
        cfg_m = 4'd1; cfg_n = 4'd8; start1 = 1'b1; poked = 1;
      end
      #1;
      if (cyc == 0) chk_i("busy_after_start", int'(o_busy), 1);
      if (o_rd_en) begin
        chk_i("read_in_range", int'(reads < total), 1);
        ea = AW'((reads < total) ? exp_q[reads] : 0);
        chk("rd_addr", DW'(o_rd_addr), DW'({LANES{ea}}));
        chk_i("credit_limit", int'((reads + 1 - beats) <= depth), 1);
        reads++;
      end
      if (hold) begin
        chk_i("stall_valid", int'(o_valid), 1);
        chk("stall_data", o_data, hold_data);
        chk_i("stall_last", int'(o_last), int'(hold_last));
      end
      if (total == 0) chk_i("empty_cfg_valid", int'(o_valid), 0);
      if (mode == 1 && !out_ready && stall_cnt == 19) begin
        chk_i("stall_rd_en_off", int'(o_rd_en), 0);
        chk_i("stall_outstanding", reads - beats, depth);
      end
      if (o_valid && out_ready) begin
        chk_i("beat_in_range", int'(beats < total), 1);
        if (beats < total) begin
          chk("beat_data", o_data, table_row(AW'(exp_q[beats])));
          chk_i("beat_last", int'(o_last), int'(beats == total - 1));
        end
        beats++;
        if (beats == total) last_cyc = cyc;
      end
      hold = o_valid && !out_ready;
      hold_data = o_data;
      hold_last = o_last;
      if (o_done) begin
        done_cnt++;
        chk_i("done_timing", cyc, last_cyc + 1);
      end
      if (mode == 1 && !out_ready) stall_cnt++;
      if (abort_at >= 0 && beats == abort_at) break;
      if (done_cnt > 0 && cyc >= last_cyc + 3) break;
      @(negedge clk);
    end
    start1 = 1'b0;
    out_ready = 1'b1;

    if (abort_at >= 0) begin
      chk_i("abort_reached", beats, abort_at);
      rst_n = 1'b0;
      @(negedge clk); #1;
      chk_i("abort_rd_en", int'(o_rd_en), 0);
      chk("abort_rd_addr", DW'(o_rd_addr), '0);
      chk_i("abort_valid", int'(o_valid), 0);
      chk_i("abort_last", int'(o_last), 0);
      chk_i("abort_busy", int'(o_busy), 0);
      chk_i("abort_done", int'(o_done), 0);
      rst_n = 1'b1;
      repeat (3) begin
        @(negedge clk); #1;
        chk_i("post_abort_valid", int'(o_valid), 0);
        chk_i("post_abort_busy", int'(o_busy), 0);
        chk_i("post_abort_done", int'(o_done), 0);
      end
    end else begin
      chk_i("total_reads", reads, total);
      chk_i("total_beats", beats, total);
      chk_i("done_once", done_cnt, 1);
      chk_i("idle_after_done", int'(o_busy), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; out_ready = 1'b1;
    cfg_m = 4'd0; cfg_n = 4'd0; sel = 0;
    repeat (3) @(negedge clk);
    #1;
    chk_i("reset_rd_en", int'(rd_en1), 0);
    chk("reset_rd_addr", DW'(rd_addr1), '0);
    chk_i("reset_valid", int'(out_valid1), 0);
    chk_i("reset_last", int'(out_last1), 0);
    chk_i("reset_busy", int'(busy1), 0);
    chk_i("reset_done", int'(done1), 0);
    chk_i("reset_valid3", int'(out_valid3), 0);
    chk_i("reset_busy3", int'(busy3), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full 8x8 drain, ready held high.
    run_drain(8, 8, 0, -1, 0);
    // 2x3 drain with a 20-cycle downstream stall.
    run_drain(2, 3, 1, -1, 0);
    // Zero-sized configurations.
    run_drain(8, 0, 0, -1, 0);
    run_drain(0, 2, 0, -1, 0);
    // Reset at beat 40, then a clean drain from address 0.
    run_drain(8, 8, 0, 40, 0);
    run_drain(8, 8, 0, -1, 0);
    // Start re-asserted while busy.
    run_drain(8, 8, 0, -1, 1);
    // RD_LATENCY=3 instance, random back-pressure.
    sel = 1;
    run_drain(4, 4, 2, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
